pe_array_id_loader: RTL and testbench

Sequencer that walks the PE-array ID tables produced by `pe_array_id_generator` and streams every entry into the PE array's configuration port. The entries cover filter, ifmap, ipsum and opsum X/Y IDs plus the LN config word. It sits between the layer-setup logic, which issues a start pulse, and the PE array's multicast-controller ID registers. The generator is addressed through a combinational read port; the PE array accepts one entry per valid/ready handshake.

---
 rtl/pe_array_id_loader.sv | 145 ++++++++++++++
 tb/tb_pe_array_id_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_id_loader.sv
// Streams the generator's ID tables (4 buses x YID then XID, then the LN word) into the PE config port.
// Two cycles per entry (fetch, send); cfg_* hold while cfg_valid && !cfg_ready, each stall adds a cycle.
module pe_array_id_loader #(
  parameter int Y_ENTRIES = 6,
  parameter int X_ENTRIES = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] rd_sel,
  output logic       rd_y,
  output logic [5:0] rd_idx,
  input  logic [4:0] rd_data,
  input  logic [4:0] ln_config,
  output logic       cfg_valid,
  input  logic       cfg_ready,
  output logic [2:0] cfg_sel,
  output logic       cfg_y,
  output logic [5:0] cfg_addr,
  output logic [4:0] cfg_data
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [5:0] Y_LAST = 6'(Y_ENTRIES - 1);
  localparam logic [5:0] X_LAST = 6'(X_ENTRIES - 1);
  localparam logic [2:0] SEL_LN = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic       y_q, y_d;
  logic [5:0] idx_q, idx_d;
  logic       cfg_valid_q, cfg_valid_d;
  logic [2:0] cfg_sel_q, cfg_sel_d;
  logic       cfg_y_q, cfg_y_d;
  logic [5:0] cfg_addr_q, cfg_addr_d;
  logic [4:0] cfg_data_q, cfg_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    y_d         = y_q;
    idx_d       = idx_q;
    cfg_valid_d = cfg_valid_q;
    cfg_sel_d   = cfg_sel_q;
    cfg_y_d     = cfg_y_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = 3'd0;
          y_d     = 1'b1;
          idx_d   = 6'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        cfg_sel_d   = sel_q;
        cfg_y_d     = y_q;
        cfg_addr_d  = idx_q;
        cfg_data_d  = (sel_q == SEL_LN) ? ln_config : rd_data;
        cfg_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (cfg_valid_q && cfg_ready) begin
          cfg_valid_d = 1'b0;
          if (sel_q == SEL_LN) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            if (y_q) begin
              if (idx_q == Y_LAST) begin
                y_d   = 1'b0;
                idx_d = 6'd0;
              end else begin
                idx_d = idx_q + 6'd1;
              end
            end else if (idx_q == X_LAST) begin
              // Bus 3 rolls into the LN step, which is addressed as an XID slot 0.
              sel_d = sel_q + 3'd1;
              y_d   = (sel_q != 3'd3);
              idx_d = 6'd0;
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      y_q         <= 1'b0;
      idx_q       <= 6'd0;
      cfg_valid_q <= 1'b0;
      cfg_sel_q   <= 3'd0;
      cfg_y_q     <= 1'b0;
      cfg_addr_q  <= 6'd0;
      cfg_data_q  <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_sel_q   <= cfg_sel_d;
      cfg_y_q     <= cfg_y_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_sel    = sel_q[1:0];
  assign rd_y      = y_q;
  assign rd_idx    = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_sel   = cfg_sel_q;
  assign cfg_y     = cfg_y_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;

endmodule

// File: tb/tb_pe_array_id_loader.sv
// Directed bench for pe_array_id_loader with a behavioural generator table model.
module tb_pe_array_id_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] rd_sel;
  logic       rd_y;
  logic [5:0] rd_idx;
  logic [4:0] rd_data;
  logic [4:0] ln_config;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_sel;
  logic       cfg_y;
  logic [5:0] cfg_addr;
  logic [4:0] cfg_data;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int cyc = 0;
  int base = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int first_vld = -1;
  int done_cyc = -1;
  bit mon_en = 0;
  bit stalled = 0;
  logic [14:0] prev_ent;
  logic [4:0]  log_data [217];

  pe_array_id_loader #(.Y_ENTRIES(6), .X_ENTRIES(48)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_sel(rd_sel), .rd_y(rd_y), .rd_idx(rd_idx), .rd_data(rd_data),
    .ln_config(ln_config), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_y(cfg_y), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode 0: arbitrary tables, LN=27. Mode 1: LINEAR t=4 variant of ipsum XID / opsum YID, LN=31.
  function automatic logic [4:0] gen(input int md, input int s, input int y, input int i);
    if (md == 1 && s == 2 && y == 0) return (i < 4) ? 5'(i) : 5'd31;
    if (md == 1 && s == 3 && y == 1) return (i == 5) ? 5'd0 : 5'(i + 1);
    if (y == 1) return 5'((s * 3 + i) % 7);
    return 5'((s * 13 + i * 5 + 1) % 31);
  endfunction

  function automatic logic [4:0] ln_val(input int md);
    return (md == 1) ? 5'd31 : 5'd27;
  endfunction

  function automatic logic [14:0] exp_entry(input int md, input int k);
    int s, r, y, i;
    if (k == 216) return {3'd4, 1'b0, 6'd0, ln_val(md)};
    s = k / 54;
    r = k % 54;
    y = (r < 6) ? 1 : 0;
    i = (r < 6) ? r : r - 6;
    return {3'(s), 1'(y), 6'(i), gen(md, s, y, i)};
  endfunction

  assign rd_data   = gen(mode, int'(rd_sel), int'(rd_y), int'(rd_idx));
  assign ln_config = ln_val(mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      stalled = 0;
    end else begin
      if (stalled)
        chk("stall_stable", {16'd0, cfg_valid, cfg_sel, cfg_y, cfg_addr, cfg_data}, {16'd0, 1'b1, prev_ent});
      if (cfg_valid && first_vld < 0) first_vld = cyc - base;
      if (cfg_valid && cfg_ready) begin
        if (hs_cnt < 217) begin
          chk("entry", {17'd0, cfg_sel, cfg_y, cfg_addr, cfg_data}, {17'd0, exp_entry(mode, hs_cnt)});
          log_data[hs_cnt] = cfg_data;
        end else begin
          chk("extra_handshake", hs_cnt, 216);
        end
        hs_cnt++;
      end
      if (cfg_valid && !cfg_ready) stall_cnt++;
      if (done) begin
        chk("done_after_217", hs_cnt, 217);
        done_cnt++;
        done_cyc = cyc - base;
      end
      stalled  = cfg_valid && !cfg_ready;
      prev_ent = {cfg_sel, cfg_y, cfg_addr, cfg_data};
    end
  end

  task automatic start_load();
    @(posedge clk); #1;
    hs_cnt = 0; done_cnt = 0; stall_cnt = 0; first_vld = -1; done_cyc = -1;
    base = cyc;
    mon_en = 1;
    cfg_ready = 1'b1;
    start = 1'b1;
  endtask

  task automatic wait_done(input bit rnd, input bit pulses);
    int iter = 0;
    while (done_cnt == 0 && iter < 3000) begin
      @(posedge clk); #1;
      iter++;
      cfg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = pulses && ((cyc - base) == 5 || (cyc - base) == 300 || (cyc - base) == 435);
    end
    start = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    chk("idle_after_done", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("no_restart", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("handshakes", hs_cnt, 217);
    chk("done_count", done_cnt, 1);
    chk("first_valid_cycle", first_vld, 2);
    chk("done_cycle", done_cyc, 435 + stall_cnt);
    chk("valid_low_idle", {31'd0, cfg_valid}, 0);
    mon_en = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    cfg_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_status", {29'd0, busy, done, cfg_valid}, 0);
    chk("reset_cfg", {17'd0, cfg_sel, cfg_y, cfg_addr, cfg_data}, 0);
    chk("reset_rd", {23'd0, rd_sel, rd_y, rd_idx}, 0);
    cfg_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_in_reset", {31'd0, busy}, 0);
    start = 1'b0;
    #2 rst_n = 1'b1;

    // Full load, ready tied high, plain tables.
    mode = 0;
    start_load();
    wait_done(1'b0, 1'b0);

    // Random backpressure.
    start_load();
    wait_done(1'b1, 1'b0);

    // start pulses at cycles 5, 300 and in DONE (435).
    start_load();
    wait_done(1'b0, 1'b1);

    // Reset during the SEND of entry 100 (cycle 202), then a fresh load.
    start_load();
    begin
      int iter = 0;
      while ((cyc - base) < 202 && iter < 1000) begin
        @(posedge clk); #1;
        iter++;
        start = 1'b0;
        cfg_ready = 1'b1;
      end
    end
    chk("pre_reset_valid", {31'd0, cfg_valid}, 1);
    chk("pre_reset_entry", {23'd0, cfg_sel, cfg_addr}, {23'd0, 3'd1, 6'd40});
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_status", {29'd0, busy, done, cfg_valid}, 0);
    chk("async_reset_cfg", {17'd0, cfg_sel, cfg_y, cfg_addr, cfg_data}, 0);
    chk("async_reset_rd", {23'd0, rd_sel, rd_y, rd_idx}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    start_load();
    wait_done(1'b0, 1'b0);

    // LINEAR generator variant.
    mode = 1;
    start_load();
    wait_done(1'b0, 1'b0);
    for (int j = 0; j < 5; j++)
      chk("linear_ipsum_xid", {27'd0, log_data[114 + j]}, (j < 4) ? j : 31);
    chk("linear_ln", {27'd0, log_data[216]}, 31);
    chk("linear_opsum_yid5", {27'd0, log_data[167]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
